register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   32 x 32-bit general-purpose register file for the single-cycle/pipelined MIPS datapath.
//   Two combinational read ports feed ALU operands; one synchronous write port is driven by
//   write-back. Register $0 is hardwired to zero.
// PARAMETERS
//   DATA_WIDTH  32  width of each register and of the data ports
//   ADDR_WIDTH  5   width of register specifiers
//   NUM_REGS    32  number of registers; must equal 2**ADDR_WIDTH
// PORTS
//   Clk            in   1           clock; all state changes on rising edge
//   Reset          in   1           synchronous, active-high reset
//   ReadRegister1  in   ADDR_WIDTH  read port 1 register index
//   ReadRegister2  in   ADDR_WIDTH  read port 2 register index
//   WriteRegister  in   ADDR_WIDTH  write port register index
//   WriteData      in   DATA_WIDTH  value to write
//   RegWrite       in   1           write enable, active-high
//   ReadData1      out  DATA_WIDTH  contents of ReadRegister1
//   ReadData2      out  DATA_WIDTH  contents of ReadRegister2
// BEHAVIOUR
//   - One clock (Clk); reset is synchronous and active-high (Reset); no async paths.
//   - Reset: on a rising Clk edge with Reset=1, all NUM_REGS registers are cleared to 0.
//     Reset has priority over RegWrite in the same cycle (the write is dropped).
//   - Write: on a rising Clk edge with Reset=0 and RegWrite=1, reg[WriteRegister] <= WriteData.
//     Written value is visible on the read ports after that edge (1-cycle write latency).
//   - RegWrite=0: no register changes, regardless of WriteRegister/WriteData.
//   - Register 0: writes to index 0 are ignored; reading index 0 always returns 0.
//   - Read: ReadDataN = reg[ReadRegisterN], purely combinational, zero-cycle latency;
//     both ports are independent and may address the same register.
//   - After reset, and before any write, both outputs read 0 for every index.
//   - X/Z on RegWrite is treated as no-write; no other handshake exists.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined: write-through forwarding. If RegWrite=1, Reset=0,
//     WriteRegister!=0 and ReadRegisterN==WriteRegister, ReadDataN = WriteData in the same
//     cycle (before the edge). Bypass is suppressed while Reset=1 or for index 0.
//   REGFILE_BYPASS_EN undefined: reads always return stored contents; a same-cycle
//     read of the register being written returns the old value until the rising edge.
// TESTING
//   1. Reset: assert Reset 1 cycle, read all pairs (0,1)...(30,31) -> all ReadData = 0.
//   2. Fill: RegWrite=1, write i*3 to regs 8..24 (one per cycle); RegWrite=0; read pairs
//      (8,9),(10,11)...(24,25) -> ReadData1=i*3, ReadData2=(i+1)*3 except reg 25 = 0.
//   3. Zero reg: write 32'hDEADBEEF to reg 0 -> ReadData1 for index 0 stays 32'h0.
//   4. Write disable: RegWrite=0, WriteRegister=9, WriteData=32'h1234 -> reg 9 keeps 27.
//   5. Reset priority: Reset=1 and RegWrite=1 writing 32'hFFFF to reg 10 same edge -> reg 10 = 0.
//   6. Same-cycle read/write reg 12 with 32'hA5A5A5A5: with REGFILE_BYPASS_EN output
//      is A5A5A5A5 before the edge; without, old value (36) until the edge, then A5A5A5A5.

Source files
------------

// File: rtl/register_file.sv
// register_file: 32 x 32-bit MIPS GPR file, two combinational read ports, one synchronous write.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data onto matching read ports.
module register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  wr_en;

    // An unknown RegWrite makes wr_en unknown, which an if treats as false: no write.
    assign wr_en = RegWrite && (WriteRegister != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[WriteRegister] = WriteData;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        ReadData1 = regs_q[ReadRegister1];
        ReadData2 = regs_q[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
        // wr_en already excludes index 0, so $0 is never forwarded.
        if (!Reset && wr_en && (ReadRegister1 == WriteRegister)) begin
            ReadData1 = WriteData;
        end
        if (!Reset && wr_en && (ReadRegister2 == WriteRegister)) begin
            ReadData2 = WriteData;
        end
`else
`endif
        if (ReadRegister1 == '0) begin
            ReadData1 = '0;
        end
        if (ReadRegister2 == '0) begin
            ReadData2 = '0;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table, scoreboard queue, hand-written corner cases.
module tb_register_file;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          Clk;
    logic          Reset;
    logic [AW-1:0] ReadRegister1;
    logic [AW-1:0] ReadRegister2;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;
    logic          RegWrite;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;

    register_file #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_REGS  (32)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .RegWrite     (RegWrite),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2)
    );

    typedef struct {
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
    } rd_vec_t;

    typedef struct {
        string         name;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
    } sb_t;

    sb_t           sb_q[$];
    rd_vec_t       fill_vec[9];
    logic [DW-1:0] mdl[32];
    int            n_pass;
    int            n_total;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic compare(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive read addresses and queue the expectation for the check that follows.
    task automatic drive_read(input string name, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                              input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        sb_t e;
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        e.name = name;
        e.exp1 = e1;
        e.exp2 = e2;
        sb_q.push_back(e);
    endtask

    task automatic check_outputs();
        sb_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            compare({e.name, "/rd1"}, ReadData1, e.exp1);
            compare({e.name, "/rd2"}, ReadData2, e.exp2);
        end
    endtask

    task automatic read_check(input string name, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                              input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        drive_read(name, a1, a2, e1, e2);
        check_outputs();
    endtask

    initial begin
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        n_pass  = 0;
        n_total = 0;

        for (int i = 0; i < 9; i++) begin
            fill_vec[i].ra1  = AW'(8 + 2 * i);
            fill_vec[i].ra2  = AW'(9 + 2 * i);
            fill_vec[i].exp1 = DW'((8 + 2 * i) * 3);
            fill_vec[i].exp2 = (9 + 2 * i == 25) ? '0 : DW'((9 + 2 * i) * 3);
        end

        Reset         = 1'b1;
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        tick();
        Reset = 1'b0;

        // Reset state: every pair reads zero.
        for (int i = 0; i < 16; i++) begin
            read_check("reset", AW'(2 * i), AW'(2 * i + 1), '0, '0);
        end

        // Fill regs 8..24 with i*3.
        RegWrite = 1'b1;
        for (int i = 8; i <= 24; i++) begin
            WriteRegister = AW'(i);
            WriteData     = DW'(i * 3);
            tick();
        end
        RegWrite = 1'b0;
        for (int i = 0; i < 9; i++) begin
            read_check("fill", fill_vec[i].ra1, fill_vec[i].ra2, fill_vec[i].exp1, fill_vec[i].exp2);
        end

        // $0 ignores writes, before and after the edge.
        RegWrite      = 1'b1;
        WriteRegister = '0;
        WriteData     = 32'hDEADBEEF;
        read_check("zero_pre", '0, 5'd8, '0, 32'd24);
        tick();
        RegWrite = 1'b0;
        read_check("zero_post", '0, '0, '0, '0);

        // RegWrite=0 leaves reg 9 untouched.
        WriteRegister = 5'd9;
        WriteData     = 32'h1234;
        tick();
        read_check("wr_dis", 5'd9, 5'd9, 32'd27, 32'd27);

        // Same-cycle read of the register being written.
        RegWrite      = 1'b1;
        WriteRegister = 5'd12;
        WriteData     = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
        read_check("same_cyc_pre", 5'd12, 5'd13, 32'hA5A5A5A5, 32'd39);
`else
        read_check("same_cyc_pre", 5'd12, 5'd13, 32'd36, 32'd39);
`endif
        tick();
        RegWrite = 1'b0;
        read_check("same_cyc_post", 5'd12, 5'd11, 32'hA5A5A5A5, 32'd33);

        // Reset wins over a simultaneous write and suppresses forwarding.
        Reset         = 1'b1;
        RegWrite      = 1'b1;
        WriteRegister = 5'd10;
        WriteData     = 32'hFFFF;
        read_check("rst_prio_pre", 5'd10, 5'd9, 32'd30, 32'd27);
        tick();
        Reset    = 1'b0;
        RegWrite = 1'b0;
        read_check("rst_prio_post", 5'd10, 5'd9, '0, '0);

        // Random writes against a reference model, then full readback.
        for (int i = 0; i < 32; i++) begin
            mdl[i] = '0;
        end
        for (int k = 0; k < 24; k++) begin
            wa            = AW'($urandom_range(0, 31));
            wd            = $urandom;
            RegWrite      = ($urandom_range(0, 3) != 0);
            WriteRegister = wa;
            WriteData     = wd;
            if (RegWrite && wa != '0) begin
                mdl[wa] = wd;
            end
            tick();
        end
        RegWrite = 1'b0;
        for (int i = 0; i < 16; i++) begin
            read_check("random", AW'(31 - 2 * i), AW'(2 * i), mdl[31 - 2 * i], mdl[2 * i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
